// File: rtl/pipe_hazard_ctrl.sv
// Hazard/interlock controller beside decode: writer table, youngest-first forwarding,
// load-use stall, freeze on memory wait, flush bubbles. HAZ_PERF_EN adds stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int STAGES     = 2,
    parameter int LOAD_STAGE = 2,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16,
    localparam int SW        = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_wr,
    input  logic              id_is_load,
    input  logic              br_flush,
    input  logic              mem_busy,
    output logic [SW-1:0]     fwd1_sel,
    output logic [SW-1:0]     fwd2_sel,
    output logic              stall_id,
    output logic              freeze,
    output logic              inj_bubble,
    output logic [STAGES-1:0] stage_valid
`ifdef HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    if (STAGES < 1 || STAGES > 7 || LOAD_STAGE < 1 || LOAD_STAGE > STAGES || CNT_W < 1) begin : g_param_err
        $error("pipe_hazard_ctrl: illegal STAGES/LOAD_STAGE/CNT_W");
    end

    // Index p-1 holds position p (position 1 = youngest).
    logic [STAGES-1:0]             vld_q, vld_d;
    logic [STAGES-1:0]             ld_q, ld_d;
    logic [STAGES-1:0][REG_AW-1:0] rd_q, rd_d;
    logic                          hz1, hz2, new_vld;

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        logic rdy;
        rdy      = 1'b0;
        fwd1_sel = '0;
        fwd2_sel = '0;
        hz1      = 1'b0;
        hz2      = 1'b0;
        for (int p = STAGES; p >= 1; p--) begin
            rdy = !ld_q[p-1] || (p >= LOAD_STAGE);
            if (id_rs1_used && id_rs1 != '0 && vld_q[p-1] && rd_q[p-1] == id_rs1) begin
                fwd1_sel = rdy ? SW'(p) : '0;
                hz1      = !rdy;
            end
            if (id_rs2_used && id_rs2 != '0 && vld_q[p-1] && rd_q[p-1] == id_rs2) begin
                fwd2_sel = rdy ? SW'(p) : '0;
                hz2      = !rdy;
            end
        end
    end

    assign freeze      = mem_busy;
    assign stall_id    = id_valid && !br_flush && (hz1 || hz2);
    assign inj_bubble  = !freeze && (stall_id || br_flush || !id_valid);
    assign new_vld     = id_valid && id_reg_wr && (id_rd != '0) && !stall_id && !br_flush;
    assign stage_valid = vld_q;

    always_comb begin
        vld_d = vld_q;
        ld_d  = ld_q;
        rd_d  = rd_q;
        if (!freeze) begin
            for (int p = STAGES - 1; p >= 1; p--) begin
                vld_d[p] = vld_q[p-1];
                ld_d[p]  = ld_q[p-1];
                rd_d[p]  = rd_q[p-1];
            end
            vld_d[0] = new_vld;
            ld_d[0]  = id_is_load;
            rd_d[0]  = id_rd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            ld_q  <= '0;
            rd_q  <= '0;
        end else begin
            vld_q <= vld_d;
            ld_q  <= ld_d;
            rd_q  <= rd_d;
        end
    end

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    // Saturating; a frozen cycle is not a counted event.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!freeze) begin
            if (stall_id && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
            if (br_flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two configurations (2/2 and 4/3) on shared stimulus,
// checked each cycle against a position-table model, plus literal scenario checks.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_rs1_used, id_rs2_used, id_reg_wr, id_is_load, br_flush, mem_busy;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic [1:0] a_fwd1_sel, a_fwd2_sel, a_stage_valid;
    logic [2:0] b_fwd1_sel, b_fwd2_sel;
    logic [3:0] b_stage_valid;
    logic       a_stall_id, a_freeze, a_inj_bubble, b_stall_id, b_freeze, b_inj_bubble;
`ifdef HAZ_PERF_EN
    logic [15:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.STAGES(2), .LOAD_STAGE(2), .REG_AW(5), .CNT_W(16)) u_a (
`ifdef HAZ_PERF_EN
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt),
`endif
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_wr(id_reg_wr), .id_is_load(id_is_load), .br_flush(br_flush),
        .mem_busy(mem_busy), .fwd1_sel(a_fwd1_sel), .fwd2_sel(a_fwd2_sel),
        .stall_id(a_stall_id), .freeze(a_freeze), .inj_bubble(a_inj_bubble),
        .stage_valid(a_stage_valid));

    pipe_hazard_ctrl #(.STAGES(4), .LOAD_STAGE(3), .REG_AW(5), .CNT_W(16)) u_b (
`ifdef HAZ_PERF_EN
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt),
`endif
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_wr(id_reg_wr), .id_is_load(id_is_load), .br_flush(br_flush),
        .mem_busy(mem_busy), .fwd1_sel(b_fwd1_sel), .fwd2_sel(b_fwd2_sel),
        .stall_id(b_stall_id), .freeze(b_freeze), .inj_bubble(b_inj_bubble),
        .stage_valid(b_stage_valid));

    // Model: per configuration, what writer sits at each position 1..N.
    bit mv[2][8];
    int mrd[2][8];
    bit mld[2][8];
    int mst[2];
    int mfl[2];

    function automatic int ns(int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic int ls(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int youngest(int i, int a, bit used);
        if (!used || a == 0) return 0;
        for (int p = 1; p <= ns(i); p++)
            if (mv[i][p] && mrd[i][p] == a) return p;
        return 0;
    endfunction

    function automatic bit ready(int i, int p);
        return !mld[i][p] || p >= ls(i);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 8; p++) begin
                mv[i][p] = 0; mrd[i][p] = 0; mld[i][p] = 0;
            end
            mst[i] = 0; mfl[i] = 0;
        end
    endtask

    task automatic chk(string nm, int i, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[cfg%0d] t=%0t actual=%0d expected=%0d", nm, i, $time, act, exp);
        end
    endtask

    task automatic lit(string nm, int act, int exp);
        chk(nm, 9, act, exp);
    endtask

    task automatic check_cycle();
        int  p1, p2, sv, a1, a2, as, ai, af, asv;
        bit  stl, inj, nv;
        if (!reset) clear_model();
        for (int i = 0; i < 2; i++) begin
            p1  = youngest(i, int'(id_rs1), id_rs1_used);
            p2  = youngest(i, int'(id_rs2), id_rs2_used);
            stl = id_valid && !br_flush &&
                  ((p1 != 0 && !ready(i, p1)) || (p2 != 0 && !ready(i, p2)));
            inj = !mem_busy && (stl || br_flush || !id_valid);
            sv  = 0;
            for (int p = 1; p <= ns(i); p++) if (mv[i][p]) sv |= (1 << (p - 1));
            if (i == 0) begin
                a1 = int'(a_fwd1_sel); a2 = int'(a_fwd2_sel); as = int'(a_stall_id);
                ai = int'(a_inj_bubble); af = int'(a_freeze); asv = int'(a_stage_valid);
            end else begin
                a1 = int'(b_fwd1_sel); a2 = int'(b_fwd2_sel); as = int'(b_stall_id);
                ai = int'(b_inj_bubble); af = int'(b_freeze); asv = int'(b_stage_valid);
            end
            chk("stall_id", i, as, int'(stl));
            chk("inj_bubble", i, ai, int'(inj));
            chk("freeze", i, af, int'(mem_busy));
            chk("stage_valid", i, asv, sv);
            if (!stl && (p1 == 0 || ready(i, p1))) chk("fwd1_sel", i, a1, p1);
            if (!stl && (p2 == 0 || ready(i, p2))) chk("fwd2_sel", i, a2, p2);
`ifdef HAZ_PERF_EN
            chk("stall_cnt", i, (i == 0) ? int'(a_stall_cnt) : int'(b_stall_cnt), mst[i]);
            chk("flush_cnt", i, (i == 0) ? int'(a_flush_cnt) : int'(b_flush_cnt), mfl[i]);
`endif
            if (reset && !mem_busy) begin
                nv = id_valid && id_reg_wr && id_rd != 0 && !stl && !br_flush;
                for (int p = ns(i); p >= 2; p--) begin
                    mv[i][p] = mv[i][p-1]; mrd[i][p] = mrd[i][p-1]; mld[i][p] = mld[i][p-1];
                end
                mv[i][1] = nv; mrd[i][1] = int'(id_rd); mld[i][1] = id_is_load;
                if (stl && mst[i] < 65535) mst[i]++;
                if (br_flush && mfl[i] < 65535) mfl[i]++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit wr, bit ld);
        id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rs1_used = u1; id_rs2_used = u2;
        id_rd = 5'(rd); id_reg_wr = wr; id_is_load = ld;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit pf, pb;
        reset = 1'b0; br_flush = 1'b0; mem_busy = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        clear_model();
        #2;
        lit("reset_stage_valid", int'(a_stage_valid), 0);
        lit("reset_fwd1", int'(a_fwd1_sel), 0);
        lit("reset_stall", int'(a_stall_id), 0);
        step(); step();
        reset = 1'b1;

        // ALU->ALU, distance 1 then distance 2
        set_id(1, 0, 0, 0, 0, 5, 1, 0); step();
        set_id(1, 5, 7, 1, 1, 6, 1, 0); #1;
        lit("alu_fwd1_d1", int'(a_fwd1_sel), 1);
        lit("alu_fwd2_d1", int'(a_fwd2_sel), 0);
        lit("alu_stall_d1", int'(a_stall_id), 0);
        step();
        drain();
        set_id(1, 0, 0, 0, 0, 5, 1, 0); step();
        set_id(1, 0, 0, 0, 0, 10, 1, 0); step();
        set_id(1, 5, 7, 1, 1, 6, 1, 0); #1;
        lit("alu_fwd1_d2", int'(a_fwd1_sel), 2);
        step();

        // load-use: 1 stall cycle at 2/2, 2 at 4/3
        drain();
        set_id(1, 0, 0, 0, 0, 5, 1, 1); step();
        set_id(1, 5, 5, 1, 1, 6, 1, 0); #1;
        lit("lu_stall_a", int'(a_stall_id), 1);
        lit("lu_inj_a", int'(a_inj_bubble), 1);
        lit("lu_stall_b0", int'(b_stall_id), 1);
        step();
        lit("lu_release_a", int'(a_stall_id), 0);
        lit("lu_fwd1_a", int'(a_fwd1_sel), 2);
        lit("lu_fwd2_a", int'(a_fwd2_sel), 2);
        lit("lu_stall_b1", int'(b_stall_id), 1);
        step();
        lit("lu_release_b", int'(b_stall_id), 0);
        lit("lu_fwd1_b", int'(b_fwd1_sel), 3);
        step();

        // x0 never forwards; youngest x9 writer wins
        drain();
        set_id(1, 0, 0, 0, 0, 0, 1, 0); step();
        set_id(1, 0, 0, 1, 0, 3, 1, 0); #1;
        lit("x0_fwd1", int'(a_fwd1_sel), 0);
        step();
        set_id(1, 0, 0, 0, 0, 9, 1, 0); step(); step();
        set_id(1, 9, 0, 1, 0, 4, 1, 0); #1;
        lit("prio_fwd1", int'(a_fwd1_sel), 1);
        step();

        // freeze during a load-use stall
        drain();
        set_id(1, 0, 0, 0, 0, 5, 1, 1); step();
        set_id(1, 5, 5, 1, 1, 6, 1, 0); mem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            lit("frz_stall", int'(a_stall_id), 1);
            lit("frz_inj", int'(a_inj_bubble), 0);
            lit("frz_stage_valid", int'(a_stage_valid), 1);
            step();
        end
        mem_busy = 1'b0; #1;
        lit("frz_stall_after", int'(a_stall_id), 1);
        lit("frz_inj_after", int'(a_inj_bubble), 1);
        step();
        lit("frz_released", int'(a_stall_id), 0);
        step();

        // flush beats load-use stall
        drain();
        set_id(1, 0, 0, 0, 0, 5, 1, 1); step();
        set_id(1, 5, 5, 1, 1, 6, 1, 0); br_flush = 1'b1; #1;
        lit("fl_stall", int'(a_stall_id), 0);
        lit("fl_inj", int'(a_inj_bubble), 1);
        step();
        br_flush = 1'b0;

        // reset while both positions hold writers
        drain();
        set_id(1, 0, 0, 0, 0, 1, 1, 0); step();
        set_id(1, 0, 0, 0, 0, 2, 1, 0); step();
        lit("rst_before", int'(a_stage_valid), 3);
        reset = 1'b0; clear_model(); #1;
        lit("rst_stage_valid", int'(a_stage_valid), 0);
        step();
        reset = 1'b1;
        set_id(1, 1, 0, 1, 0, 3, 1, 0); #1;
        lit("rst_fwd1", int'(a_fwd1_sel), 0);
        step();

        // randomized traffic; a flush seen during a freeze is held until it is taken
        pf = 0; pb = 0;
        for (int n = 0; n < 3000; n++) begin
            set_id($urandom_range(0, 99) < 85, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            br_flush = (pf && pb) ? 1'b1 : ($urandom_range(0, 99) < 10);
            mem_busy = ($urandom_range(0, 99) < 15);
            if (n == 1500) begin
                reset = 1'b0; clear_model();
            end else begin
                reset = 1'b1;
            end
            pf = br_flush; pb = mem_busy;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and interlock controller for an in-order RISC-V pipeline with `STAGES` result-producing stages after decode. It generalises two-stage writeback-only forwarding in three ways:
- forwarding from any downstream stage, youngest producer first;
- load-use stalls for loads whose data arrives late;
- a pipeline-wide freeze on memory wait states, plus branch-flush bubble handling.

It sits beside the decode stage: decode fields go in, and forwarding-mux selects and hold/bubble controls come out.

## Interface
Parameters:
- `STAGES`, default 2: number of in-flight positions after decode. Legal range 1..7. Position `STAGES` is writeback.
- `LOAD_STAGE`, default 2: first position at which load data can be forwarded. Legal range 1..`STAGES`.
- `REG_AW`, default 5: register address width.
- `CNT_W`, default 16: width of the performance counters.

Ports (`SW` = `$clog2(STAGES+1)`):
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  decode stage holds a real instruction.
- `id_rs1`, `id_rs2`  in  `REG_AW`  source register addresses.
- `id_rs1_used`, `id_rs2_used`  in  1  the instruction actually reads that source.
- `id_rd`  in  `REG_AW`  destination register.
- `id_reg_wr`  in  1  the instruction writes `id_rd`.
- `id_is_load`  in  1  the instruction is a load.
- `br_flush`  in  1  branch/jump resolved taken; the decode instruction must be killed.
- `mem_busy`  in  1  data memory wait state; the whole pipeline holds.
- `fwd1_sel`, `fwd2_sel`  out  `SW`  forwarding select. 0 = register file; k = result at position k.
- `stall_id`  out  1  load-use interlock. PC and decode hold.
- `freeze`  out  1  global hold. Equals `mem_busy`.
- `inj_bubble`  out  1  position 1 receives a bubble on this edge.
- `stage_valid`  out  `STAGES`  bit k-1 = position k holds a register writer.
- `stall_cnt`, `flush_cnt`  out  `CNT_W`  performance counters. Present only with the macro (see Configuration).

## Operation
- **Writer table:** shift register of `STAGES` entries, each {valid, rd, is_load}.
- **Shifting:** the table shifts by one position per edge unless `freeze`=1. The entry at position `STAGES` retires.
- **New entry at position 1:** valid only when all of these hold: `id_valid`, `id_reg_wr`, `id_rd`≠0, `!stall_id`, `!br_flush`. Otherwise a bubble (valid=0) is inserted.
- **Result readiness:** an entry at position p is ready if it is not a load and p≥1, or it is a load and p≥`LOAD_STAGE`.
- **Source match:** a source matches position p when the source is used, its address is ≠0, the entry is valid, and rd equals the source address.
- **Forwarding select:** the lowest (youngest) matching p wins. `fwdN_sel`=p if that entry is ready. With no match, `fwdN_sel`=0.
- **Load-use stall:** `stall_id`=1 if the youngest match for either source is not ready, and `id_valid`=1 and `br_flush`=0. While stalled, `fwdN_sel` is don't-care.
- **Bubble injection:** `inj_bubble` = `!freeze` & (`stall_id` | `br_flush` | !`id_valid`).
- **Flush priority:** `br_flush` beats `stall_id`; `stall_id` is forced to 0.
- **Freeze handling:** `br_flush` is sampled only when `freeze`=0. Upstream holds it asserted across a freeze.
- **Register file:** has no internal write-through. Forwarding from position `STAGES` is mandatory.
- **Out-of-range parameters:** `LOAD_STAGE`>`STAGES` or `STAGES`>7 raise an elaboration-time `$error`.

## Timing
- **Combinational outputs:** `fwd*_sel`, `stall_id`, `inj_bubble` and `freeze` are combinational from the table and current inputs, with zero-cycle latency.
- **Registered outputs:** `stage_valid` and the counters.
- **Reset (async assert, sync release):**
  - every entry invalid and `stage_valid`=0;
  - `fwd*_sel`=0 and `stall_id`=0 when `id_valid` is deasserted;
  - counters = 0.
- **Reset mid-operation:** all in-flight writers are discarded immediately. The next decode reads the register file (select 0).
- **Load-use stall length:** a dependent placed directly behind a load stalls exactly `LOAD_STAGE`-1 unfrozen cycles. Cycles with `freeze`=1 extend the stall without counting.
- **Freeze:** the table is unchanged, and outputs stay stable if the inputs are stable.

## Configuration
- **`HAZ_PERF_EN` defined:**
  - `stall_cnt` increments on each edge with `stall_id`=1 and `freeze`=0.
  - `flush_cnt` increments on each edge with `br_flush`=1 and `freeze`=0.
  - Both saturate at 2^`CNT_W`-1.
- **`HAZ_PERF_EN` not defined:** the counter ports and logic are absent.

## Test plan
- **ALU→ALU forwarding** (`STAGES`=2, `LOAD_STAGE`=2): `add x5` then `add x6,x5,x7` in the next cycle → `fwd1_sel`=1, `fwd2_sel`=0, `stall_id`=0. One cycle later with an unrelated instruction between them → `fwd1_sel`=2.
- **Load-use:** `lw x5` then `add x6,x5,x5` → `stall_id`=1 and `inj_bubble`=1 for 1 cycle, then `fwd1_sel`=`fwd2_sel`=2. With `STAGES`=4, `LOAD_STAGE`=3 the stall lasts 2 cycles.
- **x0 and priority:** `addi x0` followed by a reader of x0 → select 0. Writes to x9 at positions 1 and 2 → select 1.
- **Freeze:** `mem_busy` held for 3 cycles during a load-use stall → `stage_valid` constant and `stall_id` held. The stall releases 1 cycle after `mem_busy` drops.
- **Flush with stall:** `br_flush`=1 in the same cycle as a load-use hazard → `stall_id`=0, `inj_bubble`=1, `flush_cnt` +1, `stall_cnt` unchanged.
- **Reset mid-operation:** `reset` low while `stage_valid`=2'b11 → `stage_valid`=0 immediately and counters = 0. A dependent decoded after release → select 0.
